// File: rtl/spi_frame_sender_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_frame_sender_pkg
// Description : Shared state encoding and default panel geometry for the
//               SPI frame sender.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_frame_sender_pkg;

    localparam int PANEL_W = 64;
    localparam int PANEL_H = 32;
    localparam int PIXELS  = PANEL_W * PANEL_H;

    // Wide enough for any phase, lead or trail length the sender is built with
    localparam int TIMER_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_FETCH = 3'd2,
        ST_LOW   = 3'd3,
        ST_HIGH  = 3'd4,
        ST_TRAIL = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_frame_sender_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_frame_sender_if
// Description : Control, pixel-store and SPI pin bundle of the frame sender.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_frame_sender_if #(
    parameter int ADDR_W    = $clog2(spi_frame_sender_pkg::PIXELS),
    parameter int WORD_BITS = 32
);
    logic                 start;
    logic                 abort;
    logic                 busy;
    logic                 done;
    logic                 pix_rd;
    logic [ADDR_W-1:0]    pix_addr;
    logic [WORD_BITS-1:0] pix_data;
    logic                 spi_clk;
    logic                 spi_mosi;
    logic                 spi_ss;

    modport master (
        input  start, abort, pix_data,
        output busy, done, pix_rd, pix_addr, spi_clk, spi_mosi, spi_ss
    );

    modport slave (
        output start, abort, pix_data,
        input  busy, done, pix_rd, pix_addr, spi_clk, spi_mosi, spi_ss
    );
endinterface
`default_nettype wire

// File: rtl/spi_frame_sender_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : spi_phase_timer
// Description : Loadable down-counter; o_tick is high in the N-th cycle after
//               a load of N.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_phase_timer #(
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic [CNT_W-1:0] i_count,
    output logic                  o_tick
);
    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_count;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_ONE;
        end
    end

    assign o_tick = (r_cnt == c_ONE);

endmodule
`default_nettype wire

// File: rtl/spi_frame_sender.sv
`default_nettype none
// ============================================================================
// Module      : spi_frame_sender
// Description : SPI master streaming one frame of pixel words, MSB first,
//               from a synchronous pixel store to the controller SPI slave.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_frame_sender #(
    parameter int PIXELS      = spi_frame_sender_pkg::PIXELS,
    parameter int WORD_BITS   = 32,
    parameter int HALF_PERIOD = 1,
    parameter int SS_LEAD     = 2,
    parameter int SS_TRAIL    = 2
) (
    input  wire logic          clk,
    input  wire logic          reset,
    spi_frame_sender_if.master bus
);
    import spi_frame_sender_pkg::*;

    localparam int ADDR_W = $clog2(PIXELS);
    localparam int BIT_W  = $clog2(WORD_BITS);

    localparam logic [ADDR_W-1:0]  c_LAST_ADDR = ADDR_W'(PIXELS - 1);
    localparam logic [ADDR_W-1:0]  c_ADDR_ONE  = ADDR_W'(1);
    localparam logic [BIT_W-1:0]   c_LAST_BIT  = BIT_W'(WORD_BITS - 1);
    localparam logic [BIT_W-1:0]   c_BIT_ONE   = BIT_W'(1);
    localparam logic [TIMER_W-1:0] c_HALF      = TIMER_W'(HALF_PERIOD);
    localparam logic [TIMER_W-1:0] c_LEAD      = TIMER_W'(SS_LEAD);
    localparam logic [TIMER_W-1:0] c_TRAIL     = TIMER_W'(SS_TRAIL);

    state_t               r_state;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pix_rd;
    logic [ADDR_W-1:0]    r_pix_addr;
    logic                 r_spi_clk;
    logic                 r_spi_mosi;
    logic                 r_spi_ss;
    logic [WORD_BITS-1:0] r_shreg;
    logic [BIT_W-1:0]     r_bit_cnt;

    logic                 w_tick;
    logic                 w_tmr_load;
    logic [TIMER_W-1:0]   w_tmr_count;
    logic                 w_start_ok;
    logic                 w_last_bit;
    logic                 w_last_addr;

    // A start coinciding with done is dropped so the master must re-issue it
    assign w_start_ok  = bus.start && !bus.abort && !r_done;
    assign w_last_bit  = (r_bit_cnt == c_LAST_BIT);
    assign w_last_addr = (r_pix_addr == c_LAST_ADDR);

    spi_phase_timer #(
        .CNT_W (TIMER_W)
    ) u_timer (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_tmr_load),
        .i_count (w_tmr_count),
        .o_tick  (w_tick)
    );

    always_comb begin
        w_tmr_load  = 1'b0;
        w_tmr_count = c_HALF;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_tmr_load  = 1'b1;
                    w_tmr_count = c_LEAD;
                end
            end
            ST_FETCH: w_tmr_load = !r_pix_rd;
            ST_LOW:   w_tmr_load = w_tick;
            ST_HIGH: begin
                if (w_tick && !w_last_bit) begin
                    w_tmr_load = 1'b1;
                end else if (w_tick && w_last_addr) begin
                    w_tmr_load  = 1'b1;
                    w_tmr_count = c_TRAIL;
                end
            end
            default: w_tmr_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pix_rd   <= 1'b0;
            r_pix_addr <= '0;
            r_spi_clk  <= 1'b0;
            r_spi_mosi <= 1'b0;
            r_spi_ss   <= 1'b1;
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
        end else begin
            r_done   <= 1'b0;
            r_pix_rd <= 1'b0;
            if (bus.abort && (r_state != ST_IDLE)) begin
                r_state    <= ST_IDLE;
                r_busy     <= 1'b0;
                r_pix_addr <= '0;
                r_spi_clk  <= 1'b0;
                r_spi_mosi <= 1'b0;
                r_spi_ss   <= 1'b1;
                r_bit_cnt  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_start_ok) begin
                            r_state    <= ST_LEAD;
                            r_busy     <= 1'b1;
                            r_spi_ss   <= 1'b0;
                            r_pix_addr <= '0;
                            r_bit_cnt  <= '0;
                        end
                    end
                    ST_LEAD: begin
                        if (w_tick) begin
                            r_state  <= ST_FETCH;
                            r_pix_rd <= 1'b1;
                        end
                    end
                    ST_FETCH: begin
                        // Data is valid the cycle after the strobe drops
                        if (!r_pix_rd) begin
                            r_shreg    <= bus.pix_data;
                            r_spi_mosi <= bus.pix_data[WORD_BITS-1];
                            r_bit_cnt  <= '0;
                            r_state    <= ST_LOW;
                        end
                    end
                    ST_LOW: begin
                        if (w_tick) begin
                            r_spi_clk <= 1'b1;
                            r_state   <= ST_HIGH;
                        end
                    end
                    ST_HIGH: begin
                        if (w_tick) begin
                            r_spi_clk <= 1'b0;
                            r_shreg   <= {r_shreg[WORD_BITS-2:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt + c_BIT_ONE;
                            if (!w_last_bit) begin
                                r_spi_mosi <= r_shreg[WORD_BITS-2];
                                r_state    <= ST_LOW;
                            end else if (!w_last_addr) begin
                                r_pix_addr <= r_pix_addr + c_ADDR_ONE;
                                r_pix_rd   <= 1'b1;
                                r_state    <= ST_FETCH;
                            end else begin
                                r_state <= ST_TRAIL;
                            end
                        end
                    end
                    ST_TRAIL: begin
                        if (w_tick) begin
                            r_spi_ss   <= 1'b1;
                            r_spi_mosi <= 1'b0;
                            r_done     <= 1'b1;
                            r_busy     <= 1'b0;
                            r_pix_addr <= '0;
                            r_state    <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.pix_rd   = r_pix_rd;
    assign bus.pix_addr = r_pix_addr;
    assign bus.spi_clk  = r_spi_clk;
    assign bus.spi_mosi = r_spi_mosi;
    assign bus.spi_ss   = r_spi_ss;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_frame_sender
// Description : Scoreboard bench with an SPI slave model for the frame sender.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_frame_sender;
    localparam int PIX    = 16;
    localparam int WB     = 32;
    localparam int HP     = 3;
    localparam int LEAD   = 2;
    localparam int TRAIL  = 2;
    localparam int AW     = $clog2(PIX);
    localparam int BUDGET = 10000;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    spi_frame_sender_if #(.ADDR_W(AW), .WORD_BITS(WB)) bus ();

    spi_frame_sender #(
        .PIXELS      (PIX),
        .WORD_BITS   (WB),
        .HALF_PERIOD (HP),
        .SS_LEAD     (LEAD),
        .SS_TRAIL    (TRAIL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pixel word for address a: a*0x01010101 + 0x80000001 (e.g. a=7 -> 0x87070708)
    function automatic logic [31:0] pix_val(input int a);
        logic [31:0] v;
        v = a * 32'h0101_0101 + 32'h8000_0001;
        return v;
    endfunction

    // Synchronous pixel store, one-cycle read latency
    always @(posedge clk) if (bus.pix_rd) bus.pix_data <= pix_val(int'(bus.pix_addr));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    // ---------------- SPI slave model / scoreboard monitor ----------------
    logic [31:0] exp_q[$];
    logic        p_clk = 1'b0, p_ss = 1'b1, p_mosi = 1'b0;
    logic [31:0] sh = '0;
    int nbits = 0, words = 0, rises = 0, dones = 0, mosi_age = 0, hi_len = 0;
    int exp_addr = 0, ss_fall_cyc = 0, first_rise_cyc = 0, last_fall_cyc = 0, ss_rise_cyc = 0;
    bit first_seen = 1'b0;

    always @(negedge clk) begin
        if (p_ss && !bus.spi_ss) begin
            nbits = 0; words = 0; rises = 0; exp_addr = 0;
            ss_fall_cyc = cyc; first_seen = 1'b0;
        end
        if (!p_ss && bus.spi_ss) begin
            ss_rise_cyc = cyc;
            nbits = 0;
        end
        mosi_age = (bus.spi_mosi !== p_mosi) ? 0 : mosi_age + 1;
        if (bus.spi_ss && bus.spi_clk) chk("clk_while_deselected", bus.spi_clk, 1'b0);
        if (!bus.spi_ss) begin
            if (!p_clk && bus.spi_clk) begin
                rises++;
                hi_len = 1;
                if (!first_seen) begin
                    first_seen = 1'b1;
                    first_rise_cyc = cyc;
                end
                chk("mosi_setup", 32'(mosi_age >= HP), 1);
                sh = {sh[30:0], bus.spi_mosi};
                nbits++;
                if (nbits == WB) begin
                    if (exp_q.size() == 0) begin
                        chk("word_unexpected", sh, 32'hxxxx_xxxx);
                    end else begin
                        chk("word", sh, exp_q.pop_front());
                    end
                    words++;
                    nbits = 0;
                end
            end else if (p_clk && bus.spi_clk) begin
                hi_len++;
                chk("mosi_hold", bus.spi_mosi, p_mosi);
            end else if (p_clk && !bus.spi_clk) begin
                chk("high_len", hi_len, HP);
                last_fall_cyc = cyc;
            end
        end
        if (bus.pix_rd) begin
            chk("pix_addr", bus.pix_addr, exp_addr);
            exp_addr++;
        end
        if (bus.done) begin
            dones++;
            chk("done_ss_high", bus.spi_ss, 1'b1);
        end
        p_clk  = bus.spi_clk;
        p_ss   = bus.spi_ss;
        p_mosi = bus.spi_mosi;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ss"}, bus.spi_ss, 1'b1);
        chk({tag, "_clk"}, bus.spi_clk, 1'b0);
        chk({tag, "_mosi"}, bus.spi_mosi, 1'b0);
        chk({tag, "_busy"}, bus.busy, 1'b0);
        chk({tag, "_done"}, bus.done, 1'b0);
        chk({tag, "_pix_rd"}, bus.pix_rd, 1'b0);
        chk({tag, "_addr"}, bus.pix_addr, 0);
    endtask

    task automatic start_frame();
        for (int i = 0; i < PIX; i++) exp_q.push_back(pix_val(i));
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("start_busy", bus.busy, 1'b1);
        chk("start_ss", bus.spi_ss, 1'b0);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!bus.done && n < BUDGET) begin
            step();
            n++;
        end
        if (!bus.done) timeout(name);
    endtask

    task automatic chk_full_frame(input string tag, input int exp_dones);
        chk({tag, "_rises"}, rises, PIX * WB);
        chk({tag, "_words"}, words, PIX);
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
        chk({tag, "_dones"}, dones, exp_dones);
        chk({tag, "_busy_low"}, bus.busy, 1'b0);
        chk({tag, "_trail"}, ss_rise_cyc - last_fall_cyc, TRAIL);
        chk({tag, "_lead"}, 32'(first_rise_cyc - ss_fall_cyc >= LEAD + HP), 1);
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (3) step();
        chk_idle("reset");
        reset = 1'b0;
        step();

        // Frame 1: plain full frame
        start_frame();
        wait_done("frame1_done");
        chk_full_frame("frame1", 1);

        // Frame 2: start at pixel 10 and in the done cycle are both ignored
        start_frame();
        n = 0;
        while (!(bus.pix_rd && bus.pix_addr == AW'(10)) && n < BUDGET) begin
            step();
            n++;
        end
        if (n >= BUDGET) timeout("frame2_pix10");
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done("frame2_done");
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk_full_frame("frame2", 2);
        repeat (20) step();
        chk("frame2_no_restart_ss", bus.spi_ss, 1'b1);
        chk("frame2_no_restart_busy", bus.busy, 1'b0);

        // Frame 3: abort in HIGH of word 7 bit 12
        start_frame();
        n = 0;
        while (!(words == 7 && nbits == 13 && bus.spi_clk) && n < BUDGET) begin
            step();
            n++;
        end
        if (n >= BUDGET) timeout("abort_point");
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_clk", bus.spi_clk, 1'b0);
        chk("abort_ss", bus.spi_ss, 1'b1);
        chk("abort_mosi", bus.spi_mosi, 1'b0);
        chk("abort_busy", bus.busy, 1'b0);
        step();
        bus.abort = 1'b0;
        exp_q.delete();
        repeat (30) step();
        chk("abort_no_done", dones, 2);
        chk("abort_idle_busy", bus.busy, 1'b0);

        // Frame 4: asynchronous reset at bit 100
        start_frame();
        n = 0;
        while (rises != 100 && n < BUDGET) begin
            step();
            n++;
        end
        if (n >= BUDGET) timeout("reset_point");
        reset = 1'b1;
        #1;
        chk_idle("midreset");
        step();
        reset = 1'b0;
        exp_q.delete();
        repeat (20) step();
        chk("midreset_no_done", dones, 2);

        // Frame 5: full frame after abort/reset restarts at address 0
        start_frame();
        wait_done("frame5_done");
        chk_full_frame("frame5", 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
